// File: rtl/apu_mixer.sv
// apu_mixer: N-channel audio mixer with per-channel gain RAM and mute mask.
//
// Once per output period (2^OUT_WIDTH clocks) a sequencer walks the channels,
// one per cycle. It accumulates ch_data[k]*gain[k] for every unmuted channel,
// then shifts right by SHIFT and saturates the sum to OUT_WIDTH bits. The
// result is published on the last cycle of the period and drives a 1-bit
// audio output.
//
// Optional feature macro: APU_MIXER_SDM_EN.
//   - Defined: pwm comes from a first-order sigma-delta modulator.
//   - Undefined: pwm is a counter-compare PWM.
//
// Ports:
//   clk          APU clock
//   reset        asynchronous, active-high reset
//   ch_data      packed channel samples, channel k at [k*WIDTH +: WIDTH]
//   mute         per-channel mute mask (1 = contribution forced to 0)
//   gain_wr      one-cycle gain write strobe
//   gain_addr    channel index for the gain write (>= CHANNELS is ignored)
//   gain_data    gain value for the write
//   sample       currently playing mixed sample
//   sample_valid one-cycle pulse after sample was updated
//   pwm          registered 1-bit audio output
module apu_mixer #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 4,
  parameter int GAIN_WIDTH = 4,
  parameter int OUT_WIDTH  = 8,
  parameter int SHIFT      = 1,
  localparam int AW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] ch_data,
  input  logic [CHANNELS-1:0]       mute,
  input  logic                      gain_wr,
  input  logic [AW-1:0]             gain_addr,
  input  logic [GAIN_WIDTH-1:0]     gain_data,
  output logic [OUT_WIDTH-1:0]      sample,
  output logic                      sample_valid,
  output logic                      pwm
);

  // Accumulator width: large enough that the sum of all channel products cannot overflow.
  localparam int ACC_W = WIDTH + GAIN_WIDTH + $clog2(CHANNELS) + 1;
  // Common width used when comparing the shifted sum against the output ceiling.
  localparam int CW    = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH;
  localparam logic [GAIN_WIDTH-1:0] GAIN_RST = GAIN_WIDTH'(1'b1) << (GAIN_WIDTH - 1);
  localparam logic [OUT_WIDTH-1:0]  OUT_MAX  = {OUT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    SAT  = 2'd2
  } state_e;

  // Shift the accumulated sum right by SHIFT, then clamp it to the largest output code.
  function automatic logic [OUT_WIDTH-1:0] saturate(input logic [ACC_W-1:0] a);
    logic [CW-1:0] v;
    v = CW'(a >> SHIFT);
    if (v > CW'(OUT_MAX)) begin
      saturate = OUT_MAX;
    end else begin
      saturate = v[OUT_WIDTH-1:0];
    end
  endfunction

  state_e                 state_q, state_d;
  logic [OUT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]          step_q, step_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [OUT_WIDTH-1:0]   mix_next_q, mix_next_d;
  logic [OUT_WIDTH-1:0]   sample_q, sample_d;
  logic                   valid_q, valid_d;
  logic                   pwm_q, pwm_d;
  logic [GAIN_WIDTH-1:0]  gain_q [CHANNELS];
  logic [GAIN_WIDTH-1:0]  gain_d [CHANNELS];

  logic [WIDTH-1:0]       ch_sel;
  logic [GAIN_WIDTH-1:0]  gain_sel;
  logic                   mute_sel;

  // Pick the channel, gain and mute bit addressed by the current ACC step.
  // Indices beyond CHANNELS-1 are never selected.
  always_comb begin
    ch_sel   = '0;
    gain_sel = '0;
    mute_sel = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      ch_sel   = (step_q == AW'(k)) ? ch_data[k*WIDTH +: WIDTH] : ch_sel;
      gain_sel = (step_q == AW'(k)) ? gain_q[k] : gain_sel;
      mute_sel = (step_q == AW'(k)) ? mute[k] : mute_sel;
    end
  end

  // Gain RAM write port: an address that matches no channel leaves every entry unchanged.
  // A same-cycle write lands after the ACC read, so the old gain is used this period.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      gain_d[k] = (gain_wr && (gain_addr == AW'(k))) ? gain_data : gain_q[k];
    end
  end

  // Sequencer next-state logic, period counter, publish strobe and output compare.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    acc_d      = acc_q;
    mix_next_d = mix_next_q;
    cnt_d      = cnt_q + OUT_WIDTH'(1'b1);
    case (state_q)
      IDLE: begin
        if (cnt_q == '0) begin
          state_d = ACC;
          acc_d   = '0;
          step_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (mute_sel) begin
          acc_d = acc_q;
        end else begin
          acc_d = acc_q + (ACC_W'(ch_sel) * ACC_W'(gain_sel));
        end
        step_d = step_q + AW'(1'b1);
        if (step_q == AW'(CHANNELS - 1)) begin
          state_d = SAT;
        end else begin
          state_d = ACC;
        end
      end
      SAT: begin
        mix_next_d = saturate(acc_q);
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The new mix is published on the last cycle of the period and flagged one cycle later.
    if (cnt_q == OUT_MAX) begin
      sample_d = mix_next_q;
      valid_d  = 1'b1;
    end else begin
      sample_d = sample_q;
      valid_d  = 1'b0;
    end
  end

`ifdef APU_MIXER_SDM_EN
  logic [OUT_WIDTH:0] s_q, s_d;

  // Sigma-delta modulator: the carry out of the phase accumulator is the output bit.
  always_comb begin
    s_d   = {1'b0, s_q[OUT_WIDTH-1:0]} + {1'b0, sample_q};
    pwm_d = s_d[OUT_WIDTH];
  end

  // Sigma-delta phase accumulator register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q <= '0;
    end else begin
      s_q <= s_d;
    end
  end
`else
  // Counter-compare PWM: high for `sample` out of every 2^OUT_WIDTH cycles.
  always_comb begin
    pwm_d = (cnt_q < sample_q);
  end
`endif

  // All sequencer, gain RAM and output state; reset discards any partial accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      step_q     <= '0;
      acc_q      <= '0;
      mix_next_q <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      pwm_q      <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        gain_q[k] <= GAIN_RST;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      step_q     <= step_d;
      acc_q      <= acc_d;
      mix_next_q <= mix_next_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      pwm_q      <= pwm_d;
      for (int k = 0; k < CHANNELS; k++) begin
        gain_q[k] <= gain_d[k];
      end
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign pwm          = pwm_q;

endmodule

// File: tb/tb_apu_mixer.sv
// Self-checking bench for apu_mixer.
//
// Two instances are used:
//   - a default 4-channel instance, which receives the vector table;
//   - a 3-channel instance, used for the out-of-range address and
//     same-cycle gain write cases.
//
// Expected samples are pushed to a queue when stimulus is applied. They are
// popped and compared when sample_valid reports an update.
module tb_apu_mixer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] ch_data = 16'hFFFF;
  logic [3:0]  mute = 4'b0000;
  logic        gain_wr = 1'b0;
  logic [1:0]  gain_addr = 2'd0;
  logic [3:0]  gain_data = 4'd0;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        pwm;

  logic [11:0] ch3_data = 12'hFFF;
  logic [2:0]  mute3 = 3'b000;
  logic        gwr3 = 1'b0;
  logic [1:0]  gaddr3 = 2'd0;
  logic [3:0]  gdata3 = 4'd0;
  logic [7:0]  sample3;
  logic        valid3;
  logic        pwm3;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp3_q[$];

  typedef struct {
    logic [15:0] data;
    logic [3:0]  mute;
    logic [15:0] gains;
    logic [7:0]  exp;
  } vec_t;
  vec_t vecs[10];

  apu_mixer u_dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .mute(mute),
    .gain_wr(gain_wr), .gain_addr(gain_addr), .gain_data(gain_data),
    .sample(sample), .sample_valid(sample_valid), .pwm(pwm)
  );

  apu_mixer #(.CHANNELS(3)) u_dut3 (
    .clk(clk), .reset(reset), .ch_data(ch3_data), .mute(mute3),
    .gain_wr(gwr3), .gain_addr(gaddr3), .gain_data(gdata3),
    .sample(sample3), .sample_valid(valid3), .pwm(pwm3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sample_valid && n < 400);
    check("valid_seen", 32'(sample_valid), 32'd1);
  endtask

  task automatic wait_valid3();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid3 && n < 400);
    check("valid3_seen", 32'(valid3), 32'd1);
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(name, 32'(sample), 32'(e));
    end
  endtask

  task automatic pop_check3(input string name);
    logic [7:0] e;
    if (exp3_q.size() == 0) begin
      check({name, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp3_q.pop_front();
      check(name, 32'(sample3), 32'(e));
    end
  endtask

  // Watch one full period starting at a publish point. Check the pwm high
  // count, the pulse shape and the sample_valid spacing.
  task automatic check_period(input logic [7:0] exp);
    int highs;
    int valids;
    int bad;
    logic [255:0] pat;
    highs = 0;
    valids = 0;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      pat[i] = pwm;
      highs += int'(pwm);
      valids += int'(sample_valid);
    end
    check("pwm_high_count", 32'(highs), 32'(exp));
    check("valid_per_period", 32'(valids), 32'd1);
    check("valid_at_period_end", 32'(sample_valid), 32'd1);
`ifdef APU_MIXER_SDM_EN
    if (exp == 8'd64) begin
      for (int i = 0; i < 253; i++) begin
        if ((int'(pat[i]) + int'(pat[i+1]) + int'(pat[i+2]) + int'(pat[i+3])) != 1) bad++;
      end
      check("sdm_one_in_four", 32'(bad), 32'd0);
    end
`else
    for (int i = 0; i < 256; i++) begin
      if (pat[i] !== (i < int'(exp))) bad++;
    end
    check("pwm_pattern", 32'(bad), 32'd0);
`endif
  endtask

  initial begin
    int n;

    //                  data      mute     gains     exp
    vecs[0] = '{16'hFFFF, 4'b0000, 16'h8888, 8'd240};
    vecs[1] = '{16'hFFFF, 4'b0000, 16'hFFFF, 8'd255};
    vecs[2] = '{16'hFFFA, 4'b1110, 16'hFFF8, 8'd40};
    vecs[3] = '{16'h4321, 4'b0000, 16'h4321, 8'd15};
    vecs[4] = '{16'h0000, 4'b0000, 16'hFFFF, 8'd0};
    vecs[5] = '{16'hFFFF, 4'b1111, 16'hFFFF, 8'd0};
    vecs[6] = '{16'hFFFF, 4'b0000, 16'h5000, 8'd37};
    vecs[7] = '{16'h06FF, 4'b0000, 16'h0AFF, 8'd255};
    vecs[8] = '{16'h22FF, 4'b0000, 16'hEFFF, 8'd254};
    vecs[9] = '{16'hFF88, 4'b1100, 16'h8888, 8'd64};

    // Reset values.
    tick();
    tick();
    check("rst_sample", 32'(sample), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_pwm", 32'(pwm), 32'd0);

    // First update after release: default gains 8, all data 15 -> 240.
    exp_q.push_back(8'd240);
    exp3_q.push_back(8'd180);
    reset = 1'b0;
    wait_valid(n);
    check("first_update_edges", 32'(n), 32'd256);
    pop_check("first_sample");
    check("first_valid3", 32'(valid3), 32'd1);
    pop_check3("ch3_default");

    // Reset during ch0's ACC step: outputs clear immediately.
    tick();
    reset = 1'b1;
    #1;
    check("midacc_rst_sample", 32'(sample), 32'd0);
    check("midacc_rst_pwm", 32'(pwm), 32'd0);
    check("midacc_rst_valid", 32'(sample_valid), 32'd0);
    tick();
    reset = 1'b0;
    exp_q.push_back(8'd240);
    exp3_q.push_back(8'd180);
    wait_valid(n);
    check("post_rst_update_edges", 32'(n), 32'd256);
    pop_check("post_rst_sample");
    check("post_rst_valid3", 32'(valid3), 32'd1);
    pop_check3("ch3_post_rst");

    // 3-channel instance: write to address 3 is ignored.
    gwr3 = 1'b1;
    gaddr3 = 2'd3;
    gdata3 = 4'd0;
    tick();
    gwr3 = 1'b0;
    exp3_q.push_back(8'd180);
    wait_valid3();
    pop_check3("ch3_oob_write_ignored");

    // Gain0 written in ch0's ACC cycle: old gain this period, new gain next period.
    tick();
    gwr3 = 1'b1;
    gaddr3 = 2'd0;
    gdata3 = 4'd0;
    tick();
    gwr3 = 1'b0;
    exp3_q.push_back(8'd180);
    exp3_q.push_back(8'd120);
    wait_valid3();
    pop_check3("ch3_same_cycle_old_gain");
    wait_valid3();
    pop_check3("ch3_new_gain_next_period");

    // Vector table on the 4-channel instance.
    for (int v = 0; v < 10; v++) begin
      for (int k = 0; k < 4; k++) begin
        gain_wr = 1'b1;
        gain_addr = 2'(k);
        gain_data = vecs[v].gains[k*4 +: 4];
        tick();
      end
      gain_wr = 1'b0;
      wait_valid(n);
      ch_data = vecs[v].data;
      mute = vecs[v].mute;
      exp_q.push_back(vecs[v].exp);
      wait_valid(n);
      pop_check($sformatf("vec%0d_sample", v));
      check_period(vecs[v].exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
